// File: rtl/segre_store_drain.sv
// Store buffer drain controller: grants flush slots, lane-encodes one store, tag-checks it, writes through.
// Optional hit/miss statistics counters are built when SEGRE_STORE_DRAIN_STATS_EN is defined.

package segre_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
endpackage

module segre_store_drain
  import segre_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cache_busy_i,
  output logic                 flush_chance_o,
  input  logic                 sb_data_valid_i,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  memop_data_type_e     sb_memop_data_type_i,
  output logic                 tag_req_o,
  output logic [ADDR_SIZE-1:0] tag_addr_o,
  input  logic                 tag_hit_i,
  output logic                 dwr_en_o,
  output logic [ADDR_SIZE-1:0] dwr_addr_o,
  output logic [WORD_SIZE-1:0] dwr_data_o,
  output logic [3:0]           dwr_be_o,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic [3:0]           mem_be_o,
  input  logic                 mem_ack_i,
  output logic                 misalign_o,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [CNT_W-1:0]     miss_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TAG   = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_MEM   = 3'd4
  } state_e;

  state_e               state_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [WORD_SIZE-1:0] data_r;
  logic [3:0]           be_r;
  logic [WORD_SIZE-1:0] lane_data_s;
  logic [3:0]           lane_be_s;
  logic                 misaligned_s;
  logic                 accept_s;

  // The flush slot is offered only while idle; reset forces it low in the same cycle.
  assign flush_chance_o = (state_r == S_IDLE) && !cache_busy_i && !rst_i;
  assign accept_s       = flush_chance_o && sb_data_valid_i;

  // One captured store drives the tag, data array and memory ports alike.
  assign tag_addr_o = addr_r;
  assign dwr_addr_o = addr_r;
  assign dwr_data_o = data_r;
  assign dwr_be_o   = be_r;
  assign mem_addr_o = addr_r;
  assign mem_data_o = data_r;
  assign mem_be_o   = be_r;

  // Lane encoding and alignment check of the presented store.
  always_comb begin
    lane_data_s  = {WORD_SIZE{1'b0}};
    lane_be_s    = 4'h0;
    misaligned_s = 1'b0;
    case (sb_memop_data_type_i)
      BYTE: begin
        lane_be_s   = 4'b0001 << sb_addr_i[1:0];
        lane_data_s = {4{sb_data_i[7:0]}};
      end
      HALF: begin
        lane_be_s    = 4'b0011 << {sb_addr_i[1], 1'b0};
        lane_data_s  = {2{sb_data_i[15:0]}};
        misaligned_s = sb_addr_i[0];
      end
      WORD: begin
        lane_be_s    = 4'hF;
        lane_data_s  = sb_data_i;
        misaligned_s = (sb_addr_i[1:0] != 2'b00);
      end
      // An unencodable size is dropped like a misaligned store.
      default: begin
        misaligned_s = 1'b1;
      end
    endcase
  end

  // Drain sequencer with registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      addr_r     <= {ADDR_SIZE{1'b0}};
      data_r     <= {WORD_SIZE{1'b0}};
      be_r       <= 4'h0;
      tag_req_o  <= 1'b0;
      dwr_en_o   <= 1'b0;
      mem_req_o  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      tag_req_o  <= 1'b0;
      dwr_en_o   <= 1'b0;
      misalign_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (misaligned_s) begin
              misalign_o <= 1'b1;
            end else begin
              addr_r    <= {sb_addr_i[ADDR_SIZE-1:2], 2'b00};
              data_r    <= lane_data_s;
              be_r      <= lane_be_s;
              tag_req_o <= 1'b1;
              state_r   <= S_TAG;
            end
          end
        end
        S_TAG: begin
          state_r <= S_CHECK;
        end
        S_CHECK: begin
          if (tag_hit_i) begin
            dwr_en_o <= 1'b1;
            state_r  <= S_WRITE;
          end else begin
            mem_req_o <= 1'b1;
            state_r   <= S_MEM;
          end
        end
        S_WRITE: begin
          mem_req_o <= 1'b1;
          state_r   <= S_MEM;
        end
        S_MEM: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            addr_r    <= {ADDR_SIZE{1'b0}};
            data_r    <= {WORD_SIZE{1'b0}};
            be_r      <= 4'h0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEGRE_STORE_DRAIN_STATS_EN
  logic [CNT_W-1:0] hit_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  // Tag outcome statistics, wrapping naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_CHECK) begin
      if (tag_hit_i) begin
        hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`else
  assign hit_cnt_o  = {CNT_W{1'b0}};
  assign miss_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/segre_store_drain.md
# segre_store_drain

Drain controller on the cache side of the store buffer flush interface. Grants flush slots to the store buffer, accepts one flushed store per slot, converts it to a word-aligned address plus byte enables, and performs a tag check. Policy is write-through, no-write-allocate: tag hit writes the data array and memory, miss writes memory only. Sits between the store buffer and the D-cache data/tag arrays and memory write port.

## Interface
- ADDR_SIZE, 32, address width (from segre_pkg)
- WORD_SIZE, 32, data width (from segre_pkg)
- CNT_W, 32, width of statistics counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cache_busy_i  in  1  cache port owned by a load this cycle
- flush_chance_o  out  1  store buffer may present one entry this cycle
- sb_data_valid_i  in  1  store buffer presents an entry
- sb_addr_i  in  ADDR_SIZE  store byte address
- sb_data_i  in  WORD_SIZE  store data, right-aligned (byte in [7:0], half in [15:0])
- sb_memop_data_type_i  in  memop_data_type_e  BYTE/HALF/WORD
- tag_req_o  out  1  tag lookup request
- tag_addr_o  out  ADDR_SIZE  word-aligned lookup address
- tag_hit_i  in  1  lookup result, valid the cycle after tag_req_o
- dwr_en_o  out  1  data array write strobe
- dwr_addr_o  out  ADDR_SIZE  word-aligned write address
- dwr_data_o  out  WORD_SIZE  lane-aligned write data
- dwr_be_o  out  4  byte enables
- mem_req_o  out  1  memory write request
- mem_addr_o / mem_data_o / mem_be_o  out  ADDR_SIZE / WORD_SIZE / 4  same encoding as dwr_*
- mem_ack_i  in  1  memory accepted the write
- misalign_o  out  1  one-cycle pulse: dropped misaligned store
- hit_cnt_o, miss_cnt_o  out  CNT_W  statistics (see Configuration)

## Operation
- States: IDLE, TAG, CHECK, WRITE, MEM.
- IDLE: flush_chance_o = !cache_busy_i. If flush_chance_o && sb_data_valid_i, capture addr, data, type. sb_data_valid_i without flush_chance_o is ignored.
- Alignment check at capture: HALF with addr[0]=1 or WORD with addr[1:0]≠0 is misaligned. The store is dropped, misalign_o pulses the next cycle, and the state stays IDLE.
- Otherwise go to TAG.
- TAG: tag_req_o=1, tag_addr_o={addr[ADDR_SIZE-1:2],2'b00}. Go to CHECK.
- CHECK: sample tag_hit_i. Hit goes to WRITE; miss goes to MEM.
- WRITE: dwr_en_o=1 for exactly one cycle. Go to MEM.
- MEM: mem_req_o held high with stable addr/data/be until the cycle mem_ack_i=1, then go to IDLE. Ack in the first MEM cycle is legal. mem_ack_i outside MEM is ignored.
- Lane encoding:
  - BYTE: be=4'b0001<<addr[1:0], byte replicated in all lanes.
  - HALF: be=4'b0011<<{addr[1],1'b0}, half replicated in both halves.
  - WORD: be=4'hF, data unchanged.
- Only one store in flight. flush_chance_o=0 in every state except IDLE.

## Timing
- Reset values: state IDLE; every output 0, including flush_chance_o during the reset cycle. Counters are 0.
- Accept at cycle T:
  - TAG at T+1; CHECK at T+2.
  - Hit: WRITE at T+3, MEM from T+4. With zero-wait ack, flush_chance_o is next possible at T+5.
  - Miss: MEM from T+3. With zero-wait ack, flush_chance_o is next possible at T+4.
- Misaligned store: misalign_o at T+1. flush_chance_o may be high again at T+1.
- cache_busy_i only gates flush_chance_o in IDLE. It does not stall TAG/CHECK/WRITE; the tag and data ports are granted to this block once accepted.
- Reset asserted mid-operation: the in-flight store is abandoned and all outputs are 0 the next cycle. mem_req_o may drop without ack.

## Configuration
- SEGRE_STORE_DRAIN_STATS_EN defined:
  - hit_cnt_o increments in CHECK on hit; miss_cnt_o increments in CHECK on miss.
  - Both wrap modulo 2^CNT_W and are cleared by rst_i.
- Undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Reset, then idle with cache_busy_i=0 -> flush_chance_o=1 from the first post-reset cycle; all other outputs 0.
- BYTE store addr=0x1003, data=0xAB, tag_hit_i=1, mem_ack_i=1 -> dwr_addr_o=0x1000, dwr_be_o=4'b1000, dwr_data_o=0xABABABAB at T+3; mem_req_o at T+4 with same fields; hit_cnt_o=1 (STATS_EN).
- HALF store addr=0x2002, data=0x1234, tag_hit_i=0, mem_ack_i delayed 3 cycles -> no dwr_en_o; mem_be_o=4'b1100, mem_data_o=0x12341234 held stable T+3..T+6; flush_chance_o=1 at T+7.
- WORD store addr=0x3001 -> misalign_o pulse at T+1; no tag_req_o/mem_req_o; flush_chance_o=1 at T+1 when cache_busy_i=0.
- cache_busy_i=1 in IDLE with sb_data_valid_i=1 -> flush_chance_o=0, nothing captured; drop cache_busy_i -> store accepted that cycle.
- rst_i asserted while in MEM with mem_req_o=1 -> next cycle mem_req_o=0, state IDLE, counters 0; a later mem_ack_i has no effect.
